// File: rtl/fpadd_sched_pkg.sv
// Shared constants and types for the FP32 adder round-robin scheduler.
package fpadd_sched_pkg;

  // Floating-point word width carried on every operand and result bus.
  localparam int FP_W = 32;

  // Default configuration: four clients sharing a two-cycle adder.
  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_ADD_LAT = 2;

  // Tag id field is wide enough for the largest supported client count (8).
  localparam int TAG_ID_W = 3;

  // Width of the in-flight counter output.
  localparam int INFLIGHT_W = 3;

  // One slot of the tag pipe: marks an occupied adder slot and its owner.
  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/fpadd_rr_sched_arb.sv
// Combinational rotating-priority arbiter: the search starts at ptr and
// wraps modulo NUM_REQ. The first asserted request found wins.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               grant_valid
);

  // Walk the requesters in priority order and take the first one that is asking.
  always_comb begin
    int idx;
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    idx         = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!grant_valid && req[idx]) begin
        grant[idx]  = 1'b1;
        grant_idx   = ID_W'(idx);
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fpadd_rr_sched.sv
// Round-robin front end for one shared FP32 adder. It accepts one operand
// pair per cycle, registers it onto the adder bus, and follows each accepted
// operation through a tag pipe so the sum can be returned with its owner id.
module fpadd_rr_sched
  import fpadd_sched_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ID_W    = 2,
  parameter int ADD_LAT = DEF_ADD_LAT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [FP_W*NUM_REQ-1:0] req_a,
  input  logic [FP_W*NUM_REQ-1:0] req_b,
  output logic [FP_W-1:0]         add_a,
  output logic [FP_W-1:0]         add_b,
  input  logic [FP_W-1:0]         add_result,
  output logic                    rsp_valid,
  output logic [ID_W-1:0]         rsp_id,
  output logic [FP_W-1:0]         rsp_data,
  output logic [INFLIGHT_W-1:0]   inflight
);

  logic [NUM_REQ-1:0]    grant;
  logic [ID_W-1:0]       grant_idx;
  logic                  grant_valid;
  logic [ID_W-1:0]       ptr_reg;
  logic [ID_W-1:0]       ptr_next;
  logic [FP_W-1:0]       add_a_reg;
  logic [FP_W-1:0]       add_b_reg;
  logic [FP_W-1:0]       slice_a [NUM_REQ];
  logic [FP_W-1:0]       slice_b [NUM_REQ];
  tag_t                  tag_in;
  tag_t                  tag_out;
  tag_t                  tag_pipe_reg [ADD_LAT+1];
  logic [INFLIGHT_W-1:0] inflight_reg;
  logic [INFLIGHT_W-1:0] inflight_next;
  logic                  unused_tag_id;

  // Unpack the per-requester operand buses into arrays for indexed selection.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign slice_a[gi] = req_a[FP_W*gi +: FP_W];
      assign slice_b[gi] = req_b[FP_W*gi +: FP_W];
    end
  endgenerate

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req         (req_valid),
    .ptr         (ptr_reg),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  // The adder never stalls, so the grant goes straight out as the ready.
  assign req_ready = grant;

  // Priority moves to the requester just after the winner; it stays put when idle.
  always_comb begin
    ptr_next = ptr_reg;
    if (grant_valid) begin
      if (grant_idx == ID_W'(NUM_REQ - 1)) begin
        ptr_next = '0;
      end else begin
        ptr_next = grant_idx + ID_W'(1);
      end
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_reg <= '0;
    end else begin
      ptr_reg <= ptr_next;
    end
  end

  // Operand registers load only on a grant, so the adder bus holds through bubbles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      add_a_reg <= '0;
      add_b_reg <= '0;
    end else if (grant_valid) begin
      add_a_reg <= slice_a[grant_idx];
      add_b_reg <= slice_b[grant_idx];
    end
  end

  assign add_a = add_a_reg;
  assign add_b = add_b_reg;

  // An empty slot is pushed on idle cycles, which keeps each tag aligned with its sum.
  assign tag_in.valid = grant_valid;
  assign tag_in.id    = TAG_ID_W'(grant_idx);

  // Tag pipe: one stage for the operand register plus one per adder cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s <= ADD_LAT; s++) begin
        tag_pipe_reg[s] <= '0;
      end
    end else begin
      tag_pipe_reg[0] <= tag_in;
      for (int s = 1; s <= ADD_LAT; s++) begin
        tag_pipe_reg[s] <= tag_pipe_reg[s-1];
      end
    end
  end

  // The last pipe stage lines up with the adder output in the same cycle.
  assign tag_out       = tag_pipe_reg[ADD_LAT];
  assign rsp_valid     = tag_out.valid;
  assign rsp_id        = tag_out.id[ID_W-1:0];
  assign rsp_data      = add_result;
  assign unused_tag_id = ^tag_out.id;

  // Count goes up on acceptance and down on return. When both happen, it stays the same.
  always_comb begin
    inflight_next = inflight_reg;
    case ({grant_valid, rsp_valid})
      2'b10:   inflight_next = inflight_reg + INFLIGHT_W'(1);
      2'b01:   inflight_next = inflight_reg - INFLIGHT_W'(1);
      default: inflight_next = inflight_reg;
    endcase
  end

  // In-flight counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight_reg <= '0;
    end else begin
      inflight_reg <= inflight_next;
    end
  end

  assign inflight = inflight_reg;

endmodule
